// File: rtl/morse_keyer.sv
// morse_keyer: sequences one Morse character (len + dot/dash pattern) into timed key-down/up intervals.
// Define MORSE_KEYER_ABORT_EN to add i_abort, which drops the character in flight.
//  state | meaning
//  IDLE  | ready for a character, key up
//  MARK  | key down for a dot (1 unit) or dash (3 units)
//  SPACE | key up for the 1-unit intra-character space
//  GAP   | key up for the character (3) or word (7) gap
module morse_keyer #(
   parameter int MAX_LEN = 6,
   parameter int LEN_W   = 3
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_unit_tick,
   output logic               o_tick_restart,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [LEN_W-1:0]   i_len,
   input  logic [MAX_LEN-1:0] i_pattern,
   input  logic               i_word_gap,
`ifdef MORSE_KEYER_ABORT_EN
   input  logic               i_abort,
`endif
   output logic               o_key,
   output logic               o_busy,
   output logic               o_done
);
   typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_units, w_units_nxt;
   logic [LEN_W-1:0]   r_idx, w_idx_nxt;
   logic [LEN_W-1:0]   r_len, w_len_nxt;
   logic [MAX_LEN-1:0] r_pattern, w_pattern_nxt;
   logic               r_word_gap, w_word_gap_nxt;
   logic               r_key, w_key_nxt;
   logic               r_done, w_done_nxt;
   logic               r_restart, w_restart_nxt;
   logic               w_tick, w_last_unit, w_last_elem, w_next_dash;
   logic [LEN_W-1:0]   w_len_clamp, w_idx_inc;

   // The counter is being restarted while r_restart is high, so its tick is stale then.
   assign w_tick      = i_unit_tick && !r_restart;
   assign w_last_unit = (r_units == 3'd1);
   assign w_last_elem = (r_idx == r_len - LEN_W'(1));
   assign w_idx_inc   = r_idx + LEN_W'(1);
   assign w_len_clamp = (i_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : i_len;

   always_comb begin
      w_next_dash = 1'b0;
      for (int k = 0; k < MAX_LEN; k++) begin
         if (w_idx_inc == LEN_W'(k)) w_next_dash = r_pattern[k];
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_units_nxt    = r_units;
      w_idx_nxt      = r_idx;
      w_len_nxt      = r_len;
      w_pattern_nxt  = r_pattern;
      w_word_gap_nxt = r_word_gap;
      w_restart_nxt  = 1'b0;
      w_done_nxt     = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_valid) begin
               w_pattern_nxt  = i_pattern;
               w_len_nxt      = w_len_clamp;
               w_word_gap_nxt = i_word_gap;
               w_idx_nxt      = '0;
               w_restart_nxt  = 1'b1;
               if (w_len_clamp != '0) begin
                  w_state_nxt = MARK;
                  w_units_nxt = i_pattern[0] ? 3'd3 : 3'd1;
               end else begin
                  w_state_nxt = GAP;
                  w_units_nxt = 3'd7;
               end
            end
         end
         MARK: begin
            if (w_tick) begin
               if (!w_last_unit) begin
                  w_units_nxt = r_units - 3'd1;
               end else if (w_last_elem) begin
                  w_state_nxt = GAP;
                  w_units_nxt = r_word_gap ? 3'd7 : 3'd3;
               end else begin
                  w_state_nxt = SPACE;
                  w_units_nxt = 3'd1;
               end
            end
         end
         SPACE: begin
            if (w_tick) begin
               if (!w_last_unit) begin
                  w_units_nxt = r_units - 3'd1;
               end else begin
                  w_state_nxt = MARK;
                  w_idx_nxt   = w_idx_inc;
                  w_units_nxt = w_next_dash ? 3'd3 : 3'd1;
               end
            end
         end
         GAP: begin
            if (w_tick) begin
               if (!w_last_unit) begin
                  w_units_nxt = r_units - 3'd1;
               end else begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
`ifdef MORSE_KEYER_ABORT_EN
      if (i_abort && (r_state != IDLE)) begin
         w_state_nxt   = IDLE;
         w_done_nxt    = 1'b0;
         w_restart_nxt = 1'b0;
      end
`endif
      w_key_nxt = (w_state_nxt == MARK);
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state    <= IDLE;
         r_units    <= '0;
         r_idx      <= '0;
         r_len      <= '0;
         r_pattern  <= '0;
         r_word_gap <= 1'b0;
         r_key      <= 1'b0;
         r_done     <= 1'b0;
         r_restart  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_units    <= w_units_nxt;
         r_idx      <= w_idx_nxt;
         r_len      <= w_len_nxt;
         r_pattern  <= w_pattern_nxt;
         r_word_gap <= w_word_gap_nxt;
         r_key      <= w_key_nxt;
         r_done     <= w_done_nxt;
         r_restart  <= w_restart_nxt;
      end
   end

   assign o_key          = r_key;
   assign o_done         = r_done;
   assign o_tick_restart = r_restart;
   assign o_busy         = (r_state != IDLE);
   assign o_ready        = (r_state == IDLE);
endmodule

// File: tb/tb_morse_keyer.sv
// Bench for morse_keyer: per-cycle check against a unit-timing model, with a mod-10 tick source.
`timescale 1ns/1ps
module tb_morse_keyer;
   localparam int MAX_LEN = 6;
   localparam int LEN_W   = 3;
   localparam int P       = 10;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               unit_tick, tick_restart, ready, key, busy, done;
   logic               valid = 1'b0;
   logic [LEN_W-1:0]   len = '0;
   logic [MAX_LEN-1:0] pattern = '0;
   logic               word_gap = 1'b0;
`ifdef MORSE_KEYER_ABORT_EN
   logic               abort = 1'b0;
`endif
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   morse_keyer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
      .i_clk(clk), .i_reset_n(rst_n), .i_unit_tick(unit_tick), .o_tick_restart(tick_restart),
      .i_valid(valid), .o_ready(ready), .i_len(len), .i_pattern(pattern), .i_word_gap(word_gap),
`ifdef MORSE_KEYER_ABORT_EN
      .i_abort(abort),
`endif
      .o_key(key), .o_busy(busy), .o_done(done));

   // Stand-in for mod_m_counter (M=10): restart holds count at 0 through the next edge.
   logic [3:0] cnt = '0;
   always @(posedge clk) begin
      if (tick_restart) cnt <= 4'd0;
      else cnt <= (cnt == 4'(P-1)) ? 4'd0 : cnt + 4'd1;
   end
   assign unit_tick = (cnt == 4'(P-1));

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: a character is a list of (key, units) intervals; each unit is P cycles,
   // the first interval carries the extra restart cycle, then one done cycle follows.
   typedef struct packed {logic key; logic busy; logic done; logic rst;} cyc_t;
   cyc_t gen_q[$];
   cyc_t exp_q[$];
   cyc_t cur = '0;
   int   acc_cnt = 0;
   logic m_abort;
   int   runs[$];

   function automatic void push_interval(input logic k, input int u, input logic first);
      int ncyc;
      ncyc = u * P + (first ? 1 : 0);
      for (int c = 0; c < ncyc; c++) gen_q.push_back({k, 1'b1, 1'b0, first && (c == 0)});
   endfunction

   function automatic void build(input int n_in, input logic [MAX_LEN-1:0] pat, input logic wg);
      int   n;
      logic first;
      n = (n_in > MAX_LEN) ? MAX_LEN : n_in;
      first = 1'b1;
      gen_q.delete();
      for (int i = 0; i < n; i++) begin
         push_interval(1'b1, pat[i] ? 3 : 1, first);
         first = 1'b0;
         if (i < n - 1) push_interval(1'b0, 1, first);
      end
      push_interval(1'b0, (n == 0 || wg) ? 7 : 3, first);
      gen_q.push_back({1'b0, 1'b0, 1'b1, 1'b0});
   endfunction

   function automatic void get_runs();
      runs.delete();
      for (int i = 0; i < gen_q.size(); i++) begin
         if (gen_q[i].busy) begin
            if (i == 0 || gen_q[i].key != gen_q[i-1].key) runs.push_back(1);
            else runs[runs.size()-1] = runs[runs.size()-1] + 1;
         end
      end
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         cur = '0;
      end else begin
         m_abort = 1'b0;
`ifdef MORSE_KEYER_ABORT_EN
         m_abort = abort;
`endif
         if (m_abort && cur.busy) begin
            exp_q.delete();
            cur = '0;
         end else begin
            if (valid && !cur.busy) begin
               build(int'(len), pattern, word_gap);
               exp_q = gen_q;
               acc_cnt++;
            end
            cur = (exp_q.size() > 0) ? exp_q.pop_front() : cyc_t'(4'b0);
         end
      end
   end

   always @(negedge clk) begin
      chk("key", int'(key), int'(cur.key));
      chk("busy", int'(busy), int'(cur.busy));
      chk("ready", int'(ready), int'(!cur.busy));
      chk("done", int'(done), int'(cur.done));
      chk("restart", int'(tick_restart), int'(cur.rst));
   end

   task automatic send(input int l, input logic [MAX_LEN-1:0] p, input logic wg, input int junk);
      int a0, n;
      @(negedge clk);
      a0 = acc_cnt;
      valid = 1'b1; len = LEN_W'(l); pattern = p; word_gap = wg;
      n = 0;
      while (acc_cnt == a0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", int'(acc_cnt != a0), 1);
      for (int j = 0; j < junk; j++) begin
         len = LEN_W'($urandom_range(0, 7));
         pattern = MAX_LEN'($urandom);
         word_gap = 1'($urandom);
         @(negedge clk);
      end
      valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((cur.busy || cur.done) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_timeout", int'(cur.busy), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, m;
      // Pin the model against hand-computed interval lengths.
      build(1, 6'b0, 1'b0); get_runs();
      chk("model_E_runs", runs.size(), 2);
      chk("model_E_mark", runs[0], 11);
      chk("model_E_gap", runs[1], 30);
      build(2, 6'b10, 1'b0); get_runs();
      chk("model_A_runs", runs.size(), 4);
      chk("model_A_mark0", runs[0], 11);
      chk("model_A_space", runs[1], 10);
      chk("model_A_mark1", runs[2], 30);
      chk("model_A_gap", runs[3], 30);
      build(0, 6'b0, 1'b0); get_runs();
      chk("model_len0_busy", runs[0], 71);
      build(7, 6'b0, 1'b1); get_runs();
      chk("model_len7_runs", runs.size(), 12);
      chk("model_len7_gap", runs[11], 70);

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_key", int'(key), 0);
      chk("reset_ready", int'(ready), 1);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 'E': literal timing measured straight off the DUT.
      send(1, 6'b0, 1'b0, 0);
      n = 0;
      while (key && n < 500) begin n++; @(negedge clk); end
      chk("E_key_high", n, 11);
      m = 0;
      while (busy && m < 500) begin m++; @(negedge clk); end
      chk("E_gap_low", m, 30);
      chk("E_done_pulse", int'(done), 1);
      chk("E_ready", int'(ready), 1);
      @(negedge clk);
      chk("E_done_clear", int'(done), 0);

      send(2, 6'b10, 1'b0, 0);
      wait_idle();
      send(0, 6'b0, 1'b0, 0);
      wait_idle();
      send(7, 6'b111111, 1'b0, 0);
      wait_idle();
      send(2, 6'b10, 1'b1, 15);
      wait_idle();

      // Reset in the middle of a dash.
      send(1, 6'b1, 1'b0, 0);
      repeat (15) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1 chk("midreset_key", int'(key), 0);
      chk("midreset_busy", int'(busy), 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

`ifdef MORSE_KEYER_ABORT_EN
      send(2, 6'b10, 1'b0, 0);
      repeat (14) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      send(1, 6'b0, 1'b0, 0);
      wait_idle();
`endif

      // Random characters, often back-to-back, with junk requests while busy.
      for (int c = 0; c < 30; c++) begin
         send($urandom_range(0, 7), MAX_LEN'($urandom), 1'($urandom), $urandom_range(0, 20));
         if ($urandom_range(0, 3) == 0) wait_idle();
      end
      wait_idle();
      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
